axil_view_regs: RTL and testbench
=================================

AXIL_VIEW_REGS -- requirements
Module: axil_view_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, total 32-bit word registers (power of two, 4..64).
REQ-002 SHALL have parameter NUM_RO, default 4, read-only status words occupying the top NUM_RO indices.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, AXI-Lite byte-address width (2^(ADDR_WIDTH-2) >= NUM_REGS).
REQ-004 Reset is periph_resetn, asynchronous, active-low; clock is s_axi_lite_aclk.
REQ-005 s_axi_lite_aclk  in  1  sole clock.
REQ-006 periph_resetn  in  1  async active-low reset.
REQ-007 s_axi_lite_aw{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-008 s_axi_lite_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  write data channel.
REQ-009 s_axi_lite_b{resp,valid,ready}  out/out/in  2/1/1  write response.
REQ-010 s_axi_lite_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  read address.
REQ-011 s_axi_lite_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  read data.
REQ-012 frame_sync  in  1  single-cycle pulse at frame boundary (already synchronous to s_axi_lite_aclk).
REQ-013 status_in  in  NUM_RO*32  live status words, word k maps to index NUM_REGS-NUM_RO+k.
REQ-014 cfg_out  out  (NUM_REGS-NUM_RO)*32  active (committed) configuration words.
REQ-015 cfg_commit  out  1  one-cycle pulse when active set updated.
REQ-016 irq  out  1  level interrupt, sticky commit-done flag gated by enable.

Function
REQ-017 Index = addr[2 +: ADDR_WIDTH-2]; index >= NUM_REGS SHALL return SLVERR (2'b10), no side effect, read data 0.
REQ-018 RW indices 0..NUM_REGS-NUM_RO-1 SHALL write a staging array; byte lane i updated only when wstrb[i]=1.
REQ-019 Write to RO index SHALL return SLVERR and change nothing; read of RO index returns status_in sampled at AR acceptance+1 cycle, OKAY.
REQ-020 Write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP: awready high in W_IDLE/W_HAVE_D; wready high in W_IDLE/W_HAVE_A; AW and W accepted together or in either order.
REQ-021 Staging write SHALL occur on the edge both address and data are held (entry to W_RESP); bvalid asserted next cycle, held until bready; one outstanding write.
REQ-022 Read FSM states R_IDLE, R_FETCH, R_VALID: arready only in R_IDLE; rvalid asserted exactly 2 cycles after AR handshake; rdata/rresp stable until rready.
REQ-023 RW reads SHALL return staging contents, not active contents.
REQ-024 Any successful RW write SHALL set commit_pending.
REQ-025 On frame_sync with commit_pending=1: active <= staging (whole array, atomic), pending cleared, cfg_commit pulses the following cycle, done flag set.
REQ-026 frame_sync with commit_pending=0 SHALL do nothing.
REQ-027 Staging write and frame_sync on same edge: commit takes pre-edge staging; new write lands in staging; pending remains 1.
REQ-028 Index 0 bit 31 = irq_enable, bit 30 = write-1-to-clear done flag (self-clearing, reads 0, not committed); irq = done & irq_enable (staging copy).
REQ-029 Done flag set and W1C on same edge: set wins.
REQ-030 Read and write FSMs independent; concurrent read of index being written returns pre-write value if AR handshake precedes write edge.

Reset
REQ-031 On periph_resetn low: FSMs idle, all ready/valid outputs 0, bresp/rresp 0, rdata 0, staging and active arrays 0, commit_pending 0, done 0, cfg_commit 0, irq 0.
REQ-032 Reset mid-transaction SHALL abandon it; no partial write persists beyond reset values.

Structure
REQ-033 Package mandel_pkg SHALL hold AXI_OK/AXI_ERR constants and write/read state enums.
REQ-034 Single module; no sub-modules; arrays as flattened registers, no RAM inference required.

Verification
REQ-035 AW then W 3 cycles later to 0x04, data 0xDEADBEEF, strb 0xF -> bresp OKAY; read 0x04 returns 0xDEADBEEF; cfg_out word1 still 0.
REQ-036 Write 0x08 strb 0x3 data 0x12345678 over 0xAAAAAAAA -> readback 0xAAAA5678.
REQ-037 Write word1 then frame_sync -> cfg_out word1 updated, cfg_commit one pulse; second frame_sync -> no pulse.
REQ-038 Write to index 13 (RO) and addr 0x80 -> bresp 2'b10; read 0x80 -> rresp 2'b10, rdata 0; read 0x34 with status_in word1=0x55 -> 0x55 OKAY.
REQ-039 Write index 0 = 0x80000000, frame_sync -> irq 1; write 0x40000000|0x80000000 -> irq 0.
REQ-040 Assert periph_resetn low during W_HAVE_A -> all outputs 0 immediately, subsequent read of that index 0.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared definitions for the AXI-Lite view register block: response codes,
// channel state encodings, control-bit positions and the byte-lane merge helper.
package mandel_pkg;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    // Control bits living in word 0 of the configuration space.
    localparam int IRQ_EN_BIT   = 31;
    localparam int DONE_W1C_BIT = 30;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_VALID = 2'd2
    } rd_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_view_regs.sv
// AXI-Lite register file with double-buffered configuration: software writes a
// staging copy, and the whole set is copied to the active outputs atomically on
// the next frame_sync after any change. Top indices expose live status words.
module axil_view_regs
    import mandel_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int NUM_RO     = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             s_axi_lite_aclk,
    input  logic                             periph_resetn,

    input  logic [ADDR_WIDTH-1:0]            s_axi_lite_awaddr,
    input  logic                             s_axi_lite_awvalid,
    output logic                             s_axi_lite_awready,

    input  logic [31:0]                      s_axi_lite_wdata,
    input  logic [3:0]                       s_axi_lite_wstrb,
    input  logic                             s_axi_lite_wvalid,
    output logic                             s_axi_lite_wready,

    output logic [1:0]                       s_axi_lite_bresp,
    output logic                             s_axi_lite_bvalid,
    input  logic                             s_axi_lite_bready,

    input  logic [ADDR_WIDTH-1:0]            s_axi_lite_araddr,
    input  logic                             s_axi_lite_arvalid,
    output logic                             s_axi_lite_arready,

    output logic [31:0]                      s_axi_lite_rdata,
    output logic [1:0]                       s_axi_lite_rresp,
    output logic                             s_axi_lite_rvalid,
    input  logic                             s_axi_lite_rready,

    input  logic                             frame_sync,
    input  logic [NUM_RO*32-1:0]             status_in,
    output logic [(NUM_REGS-NUM_RO)*32-1:0]  cfg_out,
    output logic                             cfg_commit,
    output logic                             irq
);

    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam int IDX_W  = ADDR_WIDTH - 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;

    logic                  bus_live_q;     // low while in reset, keeps readies at 0
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            bresp_q, bresp_d;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [31:0]           staging_q [NUM_RW];
    logic [31:0]           staging_d [NUM_RW];
    logic [31:0]           active_q  [NUM_RW];
    logic [31:0]           active_d  [NUM_RW];
    logic                  pending_q, pending_d;
    logic                  done_q, done_d;
    logic                  cfg_commit_q, cfg_commit_d;

    // ------------------------------------------------------------------
    // Handshakes and the resolved write beat
    // ------------------------------------------------------------------
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           wr_idx;
    logic                  wr_ok;
    logic                  commit;
    logic [31:0]           rd_idx;
    logic [31:0]           rd_word;
    logic                  rd_ok;
    logic                  unused_addr_lsbs;

    assign aw_hs  = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_hs   = s_axi_lite_wvalid  && s_axi_lite_wready;
    assign ar_hs  = s_axi_lite_arvalid && s_axi_lite_arready;
    assign wr_idx = 32'(wr_addr[ADDR_WIDTH-1:2]);
    assign wr_ok  = wr_idx < 32'(NUM_RW);
    assign rd_idx = 32'(rd_idx_q);
    assign commit = frame_sync && pending_q;

    // Word-aligned register map: the byte offset within a word is ignored.
    assign unused_addr_lsbs = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------

    // Write channel state register.
    always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            wr_state_q <= W_IDLE;
        end else begin
            // NOTE: state elements take non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            wr_state_q <= wr_state_d;
        end
    end

    // Next write state; also resolves which address/data pair lands this edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        wr_state_d = wr_state_q;
        wr_fire    = 1'b0;
        wr_addr    = awaddr_q;
        wr_data    = wdata_q;
        wr_strb    = wstrb_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_fire    = 1'b1;
                    wr_addr    = s_axi_lite_awaddr;
                    wr_data    = s_axi_lite_wdata;
                    wr_strb    = s_axi_lite_wstrb;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    wr_fire    = 1'b1;
                    wr_data    = s_axi_lite_wdata;
                    wr_strb    = s_axi_lite_wstrb;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    wr_fire    = 1'b1;
                    wr_addr    = s_axi_lite_awaddr;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_lite_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write channel handshake outputs decoded from state.
    always_comb begin
        s_axi_lite_awready = bus_live_q &&
                             (wr_state_q == W_IDLE || wr_state_q == W_HAVE_D);
        s_axi_lite_wready  = bus_live_q &&
                             (wr_state_q == W_IDLE || wr_state_q == W_HAVE_A);
        s_axi_lite_bvalid  = (wr_state_q == W_RESP);
        s_axi_lite_bresp   = bresp_q;
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------

    // Read channel state register.
    always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Next read state: accept, fetch for one cycle, then present until taken.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_FETCH;
            R_FETCH: rd_state_d = R_VALID;
            R_VALID: if (s_axi_lite_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read channel handshake outputs decoded from state.
    always_comb begin
        s_axi_lite_arready = bus_live_q && (rd_state_q == R_IDLE);
        s_axi_lite_rvalid  = (rd_state_q == R_VALID);
        s_axi_lite_rdata   = rdata_q;
        s_axi_lite_rresp   = rresp_q;
    end

    // Read mux: staging words for RW indices, live status for RO indices.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_idx == 32'(k)) begin
                rd_word = staging_q[k];
                rd_ok   = 1'b1;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (rd_idx == 32'(NUM_RW + k)) begin
                rd_word = status_in[32*k +: 32];
                rd_ok   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file, commit and interrupt datapath
    // ------------------------------------------------------------------

    // Next values for staging/active arrays, pending, done and response regs.
    always_comb begin
        staging_d    = staging_q;
        active_d     = active_q;
        pending_d    = pending_q;
        done_d       = done_q;
        cfg_commit_d = commit;
        bresp_d      = bresp_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;

        // The active set copies pre-edge staging, so a write on the same edge
        // lands only in staging and waits for the next frame.
        if (commit) begin
            active_d  = staging_q;
            pending_d = 1'b0;
        end

        if (wr_fire) begin
            bresp_d = wr_ok ? AXI_OK : AXI_ERR;
            if (wr_ok) begin
                for (int k = 0; k < NUM_RW; k++) begin
                    if (wr_idx == 32'(k)) begin
                        staging_d[k] = apply_wstrb(staging_q[k], wr_data, wr_strb);
                    end
                end
                pending_d = 1'b1;
                if (wr_idx == 32'd0 && wr_strb[DONE_W1C_BIT/8] && wr_data[DONE_W1C_BIT]) begin
                    done_d = 1'b0;
                end
            end
        end
        // The W1C bit is an action, never stored, so it always reads back 0.
        staging_d[0][DONE_W1C_BIT] = 1'b0;

        // A commit landing on the same edge as a clear keeps the flag set.
        if (commit) done_d = 1'b1;

        if (rd_state_q == R_FETCH) begin
            rdata_d = rd_word;
            rresp_d = rd_ok ? AXI_OK : AXI_ERR;
        end
    end

    // Datapath registers; a reset abandons any in-flight transfer.
    always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            bus_live_q   <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bresp_q      <= AXI_OK;
            rd_idx_q     <= '0;
            rdata_q      <= '0;
            rresp_q      <= AXI_OK;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            cfg_commit_q <= 1'b0;
            // NOTE: these arrays are plain flops that drive outputs directly,
            // so they are reset; a true RAM would be left unreset instead.
            for (int k = 0; k < NUM_RW; k++) begin
                staging_q[k] <= '0;
                active_q[k]  <= '0;
            end
        end else begin
            bus_live_q   <= 1'b1;
            if (aw_hs) awaddr_q <= s_axi_lite_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_lite_wdata;
                wstrb_q <= s_axi_lite_wstrb;
            end
            if (ar_hs) rd_idx_q <= s_axi_lite_araddr[ADDR_WIDTH-1:2];
            bresp_q      <= bresp_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            cfg_commit_q <= cfg_commit_d;
            staging_q    <= staging_d;
            active_q     <= active_d;
        end
    end

    // Flatten the active set onto the configuration bus.
    always_comb begin
        cfg_out = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            cfg_out[32*k +: 32] = active_q[k];
        end
    end

    assign cfg_commit = cfg_commit_q;
    assign irq        = done_q && staging_q[0][IRQ_EN_BIT];

endmodule

// File: tb/tb_axil_view_regs.sv
// Self-checking bench for axil_view_regs: directed scenarios plus a randomized
// mix of writes, reads and frame syncs compared against a behavioural model.
module tb_axil_view_regs;

    localparam int NUM_REGS = 16;
    localparam int NUM_RO   = 4;
    localparam int AW       = 8;
    localparam int NUM_RW   = NUM_REGS - NUM_RO;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [AW-1:0]          awaddr;
    logic                   awvalid, awready;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
    logic                   wvalid, wready;
    logic [1:0]             bresp;
    logic                   bvalid, bready;
    logic [AW-1:0]          araddr;
    logic                   arvalid, arready;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rvalid, rready;
    logic                   frame_sync;
    logic [NUM_RO*32-1:0]   status_in;
    logic [NUM_RW*32-1:0]   cfg_out;
    logic                   cfg_commit;
    logic                   irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the register space.
    logic [31:0] m_stage  [NUM_RW];
    logic [31:0] m_active [NUM_RW];
    bit          m_pending;
    bit          m_done;

    always #5 clk = ~clk;

    axil_view_regs #(.NUM_REGS(NUM_REGS), .NUM_RO(NUM_RO), .ADDR_WIDTH(AW)) dut (
        .s_axi_lite_aclk    (clk),
        .periph_resetn      (rst_n),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wstrb   (wstrb),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .frame_sync         (frame_sync),
        .status_in          (status_in),
        .cfg_out            (cfg_out),
        .cfg_commit         (cfg_commit),
        .irq                (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model ----------------
    function automatic void model_reset();
        for (int k = 0; k < NUM_RW; k++) begin
            m_stage[k]  = '0;
            m_active[k] = '0;
        end
        m_pending = 0;
        m_done    = 0;
    endfunction

    function automatic bit model_sync();
        if (!m_pending) return 0;
        for (int k = 0; k < NUM_RW; k++) m_active[k] = m_stage[k];
        m_pending = 0;
        m_done    = 1;
        return 1;
    endfunction

    function automatic logic [1:0] model_write(input logic [AW-1:0] addr,
                                               input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= NUM_RW) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m_stage[idx][8*b +: 8] = data[8*b +: 8];
        end
        if (idx == 0) begin
            m_stage[0][30] = 1'b0;
            if (strb[3] && data[30]) m_done = 0;
        end
        m_pending = 1;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] addr, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        resp = 2'b00;
        if (idx < NUM_RW) return m_stage[idx];
        if (idx < NUM_REGS) return status_in[32*(idx-NUM_RW) +: 32];
        resp = 2'b10;
        return 32'h0;
    endfunction

    task automatic check_cfg();
        for (int k = 0; k < NUM_RW; k++) check("cfg_out", cfg_out[32*k +: 32], m_active[k]);
        check("irq", 32'(irq), 32'(m_done && m_stage[0][31]));
    endtask

    // ---------------- bus tasks ----------------
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input bit sync_on_fire);
        bit aw_done, w_done, aw_now, w_now, exp_pulse;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid    = !aw_done && cyc >= aw_dly;
            wvalid     = !w_done && cyc >= w_dly;
            aw_now     = awvalid && awready;
            w_now      = wvalid && wready;
            frame_sync = sync_on_fire && (aw_done || aw_now) && (w_done || w_now);
            tick();
            frame_sync = 1'b0;
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshake", 32'(aw_done && w_done), 32'd1);
        if (aw_done && w_done) begin
            check("bvalid_next", 32'(bvalid), 32'd1);
            if (sync_on_fire) begin
                exp_pulse = model_sync();
                check("commit_same_edge", 32'(cfg_commit), 32'(exp_pulse));
            end
            exp_resp = model_write(addr, data, strb);
            check("bresp", 32'(bresp), 32'(exp_resp));
            bready = 1'b1;
            tick();
            bready = 1'b0;
            check("bvalid_drop", 32'(bvalid), 32'd0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit got;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        cyc = 0; got = 0; data = '0; resp = 2'b11;
        araddr  = addr;
        arvalid = 1'b1;
        while (!got && cyc < 20) begin
            got = arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(got), 32'd1);
        if (got) begin
            exp_data = model_read(addr, exp_resp);
            check("rvalid_lat1", 32'(rvalid), 32'd0);
            tick();
            check("rvalid_lat2", 32'(rvalid), 32'd1);
            data = rdata;
            resp = rresp;
            check("rdata", data, exp_data);
            check("rresp", 32'(resp), 32'(exp_resp));
            tick();
            check("rdata_hold", rdata, data);
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic do_sync();
        bit exp_pulse;
        exp_pulse  = model_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("cfg_commit", 32'(cfg_commit), 32'(exp_pulse));
        tick();
        check("cfg_commit_drop", 32'(cfg_commit), 32'd0);
        check_cfg();
    endtask

    task automatic randomize_status();
        for (int k = 0; k < NUM_RO; k++) status_in[32*k +: 32] = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          op, idx;

        rst_n = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; frame_sync = 0; status_in = '0;
        model_reset();
        tick();
        tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_commit",  32'(cfg_commit), 32'd0);
        check_cfg();
        rst_n = 1'b1;
        tick();

        // AW then W three cycles later; staging updated, active untouched.
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 3, 0);
        do_read(8'h04, rd, rs);
        check("req035_data", rd, 32'hDEADBEEF);
        check("req035_cfg1", cfg_out[32 +: 32], 32'h0);

        // Partial byte-lane write.
        do_write(8'h08, 32'hAAAAAAAA, 4'hF, 2, 0, 0);
        do_write(8'h08, 32'h12345678, 4'h3, 0, 0, 0);
        do_read(8'h08, rd, rs);
        check("req036_data", rd, 32'hAAAA5678);

        // Commit on frame_sync, then nothing on a second one.
        do_write(8'h04, 32'hCAFEF00D, 4'hF, 1, 1, 0);
        do_sync();
        check("req037_cfg1", cfg_out[32 +: 32], 32'hCAFEF00D);
        do_sync();

        // Error responses and status reads.
        do_write(8'h34, 32'h11111111, 4'hF, 0, 0, 0);
        do_write(8'h80, 32'h22222222, 4'hF, 0, 0, 0);
        do_read(8'h80, rd, rs);
        check("req038_err_resp", 32'(rs), 32'd2);
        check("req038_err_data", rd, 32'd0);
        status_in = '0;
        status_in[32 +: 32] = 32'h55;
        do_read(8'h34, rd, rs);
        check("req038_status", rd, 32'h55);
        do_sync();

        // Interrupt enable, done flag and its write-1-to-clear.
        do_write(8'h00, 32'h80000000, 4'hF, 0, 0, 0);
        do_sync();
        check("req039_irq_on", 32'(irq), 32'd1);
        do_write(8'h00, 32'hC0000000, 4'hF, 0, 2, 0);
        check("req039_irq_off", 32'(irq), 32'd0);
        do_read(8'h00, rd, rs);
        check("req039_w1c_reads0", rd, 32'h80000000);
        do_sync();

        // Write and frame_sync on the same edge: commit sees the old word.
        do_write(8'h10, 32'h44444444, 4'hF, 0, 0, 0);
        do_write(8'h0C, 32'h33333333, 4'hF, 1, 0, 1);
        check_cfg();
        check("req027_old_word", cfg_out[32*3 +: 32], 32'h0);
        do_sync();
        check("req027_new_word", cfg_out[32*3 +: 32], 32'h33333333);

        // Randomized mix against the model.
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 4));
            idx = int'($urandom_range(0, 19));
            if (op <= 1) begin
                do_write(AW'(idx*4 + int'($urandom_range(0, 3))), $urandom,
                         4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
                check("rnd_irq", 32'(irq), 32'(m_done && m_stage[0][31]));
            end else if (op <= 3) begin
                randomize_status();
                do_read(AW'(idx*4), rd, rs);
            end else begin
                do_sync();
            end
        end

        // Reset while only the address of a write has been accepted.
        do_write(8'h08, 32'h11111111, 4'hF, 0, 0, 0);
        do_sync();
        awaddr  = 8'h08;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("req040_in_have_a", 32'(wready && !awready), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("req040_awready", 32'(awready), 32'd0);
        check("req040_wready",  32'(wready),  32'd0);
        check("req040_arready", 32'(arready), 32'd0);
        check("req040_bvalid",  32'(bvalid),  32'd0);
        check("req040_rvalid",  32'(rvalid),  32'd0);
        check("req040_rdata",   rdata,        32'd0);
        check("req040_commit",  32'(cfg_commit), 32'd0);
        check_cfg();
        tick();
        rst_n = 1'b1;
        tick();
        do_read(8'h08, rd, rs);
        check("req040_readback", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
